temp_sensor_reader: RTL
=======================

// Module: temp_sensor_reader
// PURPOSE
//  Upstream stage of the temperature comparator: reads an 8-bit serial temperature sensor (SPI mode 0, read-only).
//  Periodically runs a conversion frame, deserialises 8 bits MSB-first and holds the result on temp.
//  temp drives the comparator's 8-bit temperature input directly; temp_valid marks each fresh sample.
// PARAMETERS
//  CLK_DIV        4     clk cycles per sensor_sclk half-period (>=1)
//  CS_SETUP       2     clk cycles cs_n is low before the first sclk rise (>=1)
//  SAMPLE_PERIOD  1000  clk cycles between successive conversion starts; must exceed CS_SETUP+16*CLK_DIV+1 (elaboration error otherwise)
// PORTS
//  clk          in   1  system clock, single clock domain
//  rst_n        in   1  asynchronous, active-low reset
//  enable       in   1  1 = run periodic conversions
//  sensor_miso  in   1  serial data from the sensor, valid around each sclk rise
//  sensor_sclk  out  1  serial clock to the sensor, idles low
//  sensor_cs_n  out  1  sensor chip select, active low, idles high
//  temp         out  8  last completed reading, unsigned, held between frames
//  temp_valid   out  1  one-cycle pulse when temp is updated
//  busy         out  1  1 while a frame is in progress (cs_n low or DONE)
// BEHAVIOUR
//  Reset (async, immediate): sclk=0, cs_n=1, temp=8'h00, temp_valid=0, busy=0, state=IDLE, all counters 0.
//  All outputs are registered; no combinational path from inputs to outputs.
//  FSM states: IDLE, SETUP, SHIFT, DONE, WAIT.
//   IDLE : cs_n=1. enable=1 -> SETUP; period counter cleared on that edge.
//   SETUP: cs_n=0, sclk=0 for CS_SETUP cycles -> SHIFT.
//   SHIFT: sclk toggles every CLK_DIV cycles, starting low. On the clk edge that drives sclk 0->1, miso is shifted
//          into shift_reg[0] (shift left, MSB first). After the 8th rise and its following low half-period
//          (sclk back to 0) -> DONE.
//   DONE : one cycle. cs_n=1, temp<=shift_reg, temp_valid=1 -> WAIT.
//   WAIT : cs_n=1. When period counter == SAMPLE_PERIOD-1: enable=1 -> SETUP (counter cleared), enable=0 -> IDLE.
//  Period counter runs from conversion start, so starts are exactly SAMPLE_PERIOD cycles apart while enable=1.
//  Frame length: CS_SETUP + 16*CLK_DIV cycles with cs_n low; with defaults first temp_valid 67 cycles after SETUP entry.
//  Exactly 8 sclk rising edges per frame; sclk is 0 whenever cs_n is 1.
//  enable deasserted mid-frame: frame completes and temp updates; no further frames. Never abort a frame.
//  enable toggled in WAIT: sampled only at the period boundary.
//  Reset mid-frame: all state cleared, cs_n high immediately, partial data discarded, temp=8'h00.
//  temp holds its value indefinitely in IDLE/WAIT; values 8'h00 and 8'hFF are passed unchanged (no saturation or filtering).
// STRUCTURE
//  Shared package temp_pkg: TEMP_W=8, state enum for the FSM, SPI bit count constant (8).
//  One sub-module: sclk_gen -- CLK_DIV divider producing sclk plus one-cycle rise/fall strobes, gated by run.
//  Top holds FSM, bit counter (0..8), shift register, period counter, output registers.
// TESTING
//  Bench uses a behavioural sensor model that drives miso MSB-first, changing on sclk falling edges.
//  1. enable=1, sensor word 8'hA5 -> 8 sclk rises within cs_n low, temp=8'hA5, temp_valid high exactly 1 cycle,
//     67 cycles after SETUP entry.
//  2. enable held, words 8'h00 then 8'hFF -> two temp_valid pulses exactly 1000 cycles apart, temp=00 then FF.
//  3. enable=0 from reset -> cs_n stays 1, sclk stays 0, temp=8'h00, temp_valid never pulses for 5000 cycles.
//  4. enable dropped after 3rd sclk rise, word 8'h3C -> frame completes, temp=8'h3C, then IDLE, no new cs_n low.
//  5. rst_n low after 5th sclk rise of word 8'hC3 -> cs_n=1, sclk=0, temp=8'h00 same cycle; after release next
//     complete frame of 8'h5A yields temp=8'h5A.
//  6. CLK_DIV=1, CS_SETUP=1, SAMPLE_PERIOD=20, word 8'h81 -> temp=8'h81, frame 17 cycles cs_n low, period 20.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature sensor reader: data width,
// SPI frame length and the frame sequencing state encoding.
package temp_pkg;

   localparam int TEMP_W   = 8;
   localparam int SPI_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DONE  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   // Chip select is asserted only while the sensor is being clocked or set up.
   function automatic logic cs_active(input state_t st);
      return (st == ST_SETUP) || (st == ST_SHIFT);
   endfunction

   // A frame is in progress from chip-select assertion through the result load.
   function automatic logic frame_active(input state_t st);
      return (st == ST_SETUP) || (st == ST_SHIFT) || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/temp_sensor_reader_sclk_gen.sv
// Serial clock divider: while run is high, toggles sclk every CLK_DIV clk
// cycles starting from low, and flags the clk edge that will raise or lower it.
// Dropping run returns sclk low and restarts the divider.
module sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_r;
   logic             sclk_r;
   logic             wrap_s;

   assign wrap_s = (div_cnt_r == DIV_LAST);
   assign rise   = run && wrap_s && !sclk_r;
   assign fall   = run && wrap_s && sclk_r;
   assign sclk   = sclk_r;

   // Half-period counter and sclk toggle; idles low with the counter cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
         sclk_r    <= 1'b0;
      end else if (!run) begin
         div_cnt_r <= {DIV_W{1'b0}};
         sclk_r    <= 1'b0;
      end else if (wrap_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
         sclk_r    <= !sclk_r;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic reader for an 8-bit SPI mode-0 temperature sensor. Each frame
// asserts cs_n, clocks in 8 bits MSB first and presents the word on temp
// with a one-cycle temp_valid strobe. Frames start every SAMPLE_PERIOD
// cycles while enable is high and are never cut short once started.
module temp_sensor_reader
   import temp_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int CS_SETUP      = 2,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              sensor_miso,
   output logic              sensor_sclk,
   output logic              sensor_cs_n,
   output logic [TEMP_W-1:0] temp,
   output logic              temp_valid,
   output logic              busy
);

   localparam int PER_W = $clog2(SAMPLE_PERIOD);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [PER_W-1:0] SETUP_LAST = PER_W'(CS_SETUP - 1);
   localparam logic [3:0]       BIT_LAST   = 4'(SPI_BITS);

   // Reject parameter sets where a frame could not finish inside one period.
   if (CLK_DIV < 1 || CS_SETUP < 1) begin : g_bad_timing
      $error("temp_sensor_reader: CLK_DIV and CS_SETUP must be at least 1");
   end
   if (SAMPLE_PERIOD <= CS_SETUP + 16 * CLK_DIV + 1) begin : g_bad_period
      $error("temp_sensor_reader: SAMPLE_PERIOD too short for one frame");
   end

   state_t              state_r;
   state_t              next_state_s;
   logic [PER_W-1:0]    period_cnt_r;
   logic [3:0]          bit_cnt_r;
   logic [TEMP_W-1:0]   shift_r;
   logic                cs_n_r;
   logic [TEMP_W-1:0]   temp_r;
   logic                temp_valid_r;
   logic                busy_r;
   logic                run_s;
   logic                rise_s;
   logic                fall_s;
   logic                sclk_s;
   logic                start_s;

   assign run_s   = (state_r == ST_SHIFT);
   assign start_s = (next_state_s == ST_SETUP) && (state_r != ST_SETUP);

   sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run_s),
      .sclk  (sclk_s),
      .rise  (rise_s),
      .fall  (fall_s)
   );

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Frame sequencing; enable is only looked at in IDLE and at the period boundary.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               next_state_s = ST_SETUP;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (period_cnt_r == SETUP_LAST) begin
               next_state_s = ST_SHIFT;
            end else begin
               next_state_s = ST_SETUP;
            end
         end
         ST_SHIFT: begin
            if (fall_s && (bit_cnt_r == BIT_LAST)) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            next_state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (period_cnt_r == PER_LAST) begin
               if (enable) begin
                  next_state_s = ST_SETUP;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Period counter measured from each conversion start; also times the cs_n setup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt_r <= {PER_W{1'b0}};
      end else if (start_s || (state_r == ST_IDLE)) begin
         period_cnt_r <= {PER_W{1'b0}};
      end else begin
         period_cnt_r <= period_cnt_r + PER_W'(1);
      end
   end

   // Deserialiser: capture miso on the edge that raises sclk, MSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r <= 4'd0;
         shift_r   <= {TEMP_W{1'b0}};
      end else if (state_r == ST_SETUP) begin
         bit_cnt_r <= 4'd0;
         shift_r   <= {TEMP_W{1'b0}};
      end else if (run_s && rise_s) begin
         bit_cnt_r <= bit_cnt_r + 4'd1;
         shift_r   <= {shift_r[TEMP_W-2:0], sensor_miso};
      end else begin
         bit_cnt_r <= bit_cnt_r;
         shift_r   <= shift_r;
      end
   end

   // Output registers, derived from the upcoming state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n_r       <= 1'b1;
         busy_r       <= 1'b0;
         temp_r       <= {TEMP_W{1'b0}};
         temp_valid_r <= 1'b0;
      end else begin
         cs_n_r <= !cs_active(next_state_s);
         busy_r <= frame_active(next_state_s);
         if (state_r == ST_DONE) begin
            temp_r       <= shift_r;
            temp_valid_r <= 1'b1;
         end else begin
            temp_r       <= temp_r;
            temp_valid_r <= 1'b0;
         end
      end
   end

   assign sensor_sclk = sclk_s;
   assign sensor_cs_n = cs_n_r;
   assign temp        = temp_r;
   assign temp_valid  = temp_valid_r;
   assign busy        = busy_r;

endmodule
